// File: rtl/voxel_fetcher_pkg.sv
// voxel_fetcher_pkg: shared types and helpers for the voxel fetch path.
// Optional feature macro used by the fetcher: VOXEL_SKIP_EMPTY_EN.
package voxel_fetcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } vf_state_e;

  // Camera pose consumed by the downstream rasterizer.
  typedef struct packed {
    logic signed [15:0] pos_x;
    logic signed [15:0] pos_y;
    logic signed [15:0] pos_z;
  } camera_t;

  // Limit a requested voxel count to what the coordinate space can address.
  function automatic logic [32:0] clamp_count(input logic [31:0] cnt,
                                              input int unsigned idx_bits);
    logic [32:0] lim;
    lim = (idx_bits >= 32) ? 33'h1_0000_0000 : (33'd1 << idx_bits);
    return ({1'b0, cnt} > lim) ? lim : {1'b0, cnt};
  endfunction

endpackage

// File: rtl/voxel_fetcher_sync_fifo.sv
// sync_fifo: single-clock FIFO with head-of-queue output. Push and pop in the
// same cycle are both honoured even when full, giving zero-bubble throughput.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full      = (r_count == DEPTH_L);
  assign o_empty     = (r_count == '0);
  assign o_occupancy = r_count;
  assign o_head      = r_mem[r_rd_ptr];
  assign w_do_pop    = i_pop && !o_empty;
  assign w_do_push   = i_push && (!o_full || w_do_pop);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write; contents are don't-care until pointed at by a push.
  always_ff @(posedge i_clock) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/voxel_fetcher.sv
// voxel_fetcher: reads a linear array of voxel ids over an Avalon-MM pipelined
// read master and streams them out with x/y/z coordinates derived from the
// voxel index. Optional macro VOXEL_SKIP_EMPTY_EN drops id==0 voxels.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for start; responses are discarded
// ST_ISSUE | issuing reads while FIFO credit allows
// ST_DRAIN | all reads accepted; waiting for responses and FIFO to empty
// ST_DONE  | one-cycle done pulse, then back to idle
module voxel_fetcher
  import voxel_fetcher_pkg::*;
#(
  parameter int COORD_BITS   = 8,
  parameter int PALETTE_BITS = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int ADDR_STRIDE  = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [31:0]             voxel_buffer,
  input  logic [31:0]             voxel_count,
  output logic [31:0]             m1_address,
  output logic                    m1_read,
  input  logic                    m1_waitrequest,
  input  logic [31:0]             m1_readdata,
  input  logic                    m1_readdatavalid,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PALETTE_BITS-1:0] out_id,
  output logic [COORD_BITS-1:0]   out_x,
  output logic [COORD_BITS-1:0]   out_y,
  output logic [COORD_BITS-1:0]   out_z,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done
);

  localparam int IDX_BITS = 3 * COORD_BITS;
  localparam int OCC_BITS = $clog2(FIFO_DEPTH) + 1;
  localparam logic [OCC_BITS:0] DEPTH_L = FIFO_DEPTH[OCC_BITS:0];

  // Entry widths follow the module parameters, so the type is declared here.
  typedef struct packed {
    logic [PALETTE_BITS-1:0] id;
    logic [IDX_BITS-1:0]     idx;
  } entry_t;

  vf_state_e          r_state;
  vf_state_e          w_state_next;
  logic [31:0]        r_addr;
  logic [32:0]        r_count;
  logic [32:0]        r_issued;
  logic [32:0]        r_resp_idx;
  logic [OCC_BITS-1:0] r_outstanding;

  logic               w_in_pass;
  logic               w_credit;
  logic               w_accept;
  logic               w_resp;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [OCC_BITS-1:0] w_occ;
  entry_t             w_push_entry;
  entry_t             w_head;
  logic               w_unused;

  assign w_in_pass = (r_state == ST_ISSUE) || (r_state == ST_DRAIN);
  assign w_credit  = ({1'b0, r_outstanding} + {1'b0, w_occ}) < DEPTH_L;
  assign m1_read   = (r_state == ST_ISSUE) && (r_issued < r_count) && w_credit;
  assign m1_address = r_addr;
  assign w_accept  = m1_read && !m1_waitrequest;
  assign w_resp    = m1_readdatavalid && w_in_pass;
  assign busy      = w_in_pass;
  assign done      = (r_state == ST_DONE);

`ifdef VOXEL_SKIP_EMPTY_EN
  assign w_push = w_resp && (m1_readdata[PALETTE_BITS-1:0] != '0);
`else
  assign w_push = w_resp;
`endif

  assign w_push_entry.id  = m1_readdata[PALETTE_BITS-1:0];
  assign w_push_entry.idx = r_resp_idx[IDX_BITS-1:0];

  // Index layout is {y, z, x}; outputs read as zero whenever nothing is valid.
  assign out_valid = !w_empty;
  assign w_pop     = out_valid && out_ready;
  assign out_id    = out_valid ? w_head.id : '0;
  assign out_x     = out_valid ? w_head.idx[COORD_BITS-1:0] : '0;
  assign out_z     = out_valid ? w_head.idx[2*COORD_BITS-1:COORD_BITS] : '0;
  assign out_y     = out_valid ? w_head.idx[3*COORD_BITS-1:2*COORD_BITS] : '0;
  assign out_last  = out_valid && (33'(w_head.idx) == (r_count - 33'd1));

  assign w_unused = ^{m1_readdata, r_resp_idx};

  sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clock     (clock),
    .i_reset     (reset),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_occupancy (w_occ)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state decode; the FIFO holding nothing also means no handshake is pending.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_next = (voxel_count == '0) ? ST_DONE : ST_ISSUE;
      ST_ISSUE: if (r_issued == r_count) w_state_next = ST_DRAIN;
      ST_DRAIN: if ((r_outstanding == '0) && w_empty) w_state_next = ST_DONE;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Pass bookkeeping: address, issue/response counters, outstanding reads.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_addr        <= '0;
      r_count       <= '0;
      r_issued      <= '0;
      r_resp_idx    <= '0;
      r_outstanding <= '0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_addr        <= voxel_buffer;
      r_count       <= clamp_count(voxel_count, IDX_BITS);
      r_issued      <= '0;
      r_resp_idx    <= '0;
      r_outstanding <= '0;
    end else begin
      if (w_accept) begin
        r_addr   <= r_addr + ADDR_STRIDE[31:0];
        r_issued <= r_issued + 33'd1;
      end
      if (w_resp) r_resp_idx <= r_resp_idx + 33'd1;
      case ({w_accept, w_resp})
        2'b10:   r_outstanding <= r_outstanding + OCC_BITS'(1);
        2'b01:   r_outstanding <= r_outstanding - OCC_BITS'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

endmodule
